hrm_io_ctrl: RTL and testbench
==============================

Name: hrm_io_ctrl

Overview:
- Host-side controller sitting between the board host logic (UART/loader) and the hrmcpu core.
- Feeds bytes from a valid/ready stream into the CPU INBOX and drains the CPU OUTBOX into a valid/ready stream.
- Sequences CPU execution: free-run or single-step via cpu_debug/cpu_nxtInstr.
- Optionally counts transferred bytes.

Parameters:
- CNT_W, 16, width of the in/out byte counters.

Ports:
- clk  input  1  system clock, all logic on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  host byte available
- in_data  input  8  host byte
- in_ready  output  1  controller can accept host byte
- out_valid  output  1  OUTBOX byte available to host
- out_data  output  8  OUTBOX byte
- out_ready  input  1  host accepts out_data
- run_mode  input  1  1 = free run, 0 = debug/step
- step_req  input  1  level; each rising edge requests one instruction step
- cnt_clr  input  1  synchronous clear of both counters
- in_count  output  CNT_W  bytes written to INBOX
- out_count  output  CNT_W  bytes popped from OUTBOX
- cpu_in_data  output  8  to CPU INBOX data
- cpu_in_wr  output  1  INBOX write strobe
- cpu_in_full  input  1  INBOX full
- cpu_out_data  input  8  OUTBOX head data (first-word fall-through, valid while !cpu_out_empty)
- cpu_out_rd  output  1  OUTBOX pop strobe
- cpu_out_empty  input  1  OUTBOX empty
- cpu_debug  output  1  CPU debug (halt/step) mode
- cpu_nxtInstr  output  1  single-step pulse

Behaviour:
- Reset: in_ready=1, out_valid=0, out_data=0, cpu_in_wr=0, cpu_in_data=0, cpu_out_rd=0, cpu_nxtInstr=0, cpu_debug=1 (CPU halted), counters=0, step edge detector primed with step_req=0.
- Reset mid-transfer discards held bytes; no strobe is issued after reset assertion.
- Inbox path:
  - One-entry holding register ib (ib_full flag); in_ready = !ib_full (combinational from the flag).
  - Accept on in_valid && in_ready: ib <= in_data, ib_full <= 1.
  - Write when ib_full && !cpu_in_full && !cpu_in_wr: cpu_in_wr <= 1 for exactly one cycle, cpu_in_data <= ib, ib_full <= 0 on the same edge.
  - cpu_in_wr is never high two consecutive cycles; this guards against a stale cpu_in_full.
  - Peak throughput: 1 byte / 2 cycles. Latency: in accept -> cpu_in_wr high = 1 cycle.
  - If cpu_in_full, ib holds and in_ready stays 0 until the INBOX drains.
- Outbox path FSM, states IDLE / GUARD / HOLD:
  - IDLE: if !cpu_out_empty, then out_data <= cpu_out_data, cpu_out_rd <= 1 (one cycle), go GUARD.
  - GUARD: cpu_out_rd <= 0, out_valid <= 1, go HOLD. This gives cpu_out_empty one cycle to update.
  - HOLD: out_valid=1. On out_ready: out_valid <= 0, go IDLE.
  - Peak throughput: 1 byte / 3 cycles. out_data stable while out_valid.
- Run control:
  - cpu_debug is a register <= !run_mode, so mode changes take effect one cycle later.
  - In debug mode, a rising edge on step_req (registered edge detect) gives cpu_nxtInstr <= 1 for exactly one cycle.
  - step_req held high gives exactly one pulse. step edges while run_mode=1 are ignored, not queued.
  - Mode switch and step edge in the same cycle: the pulse is issued only if run_mode=0 in that cycle.
- Counters:
  - in_count increments on each cpu_in_wr pulse; out_count increments on each cpu_out_rd pulse.
  - Both wrap from all-ones to 0.
  - cnt_clr has priority over a simultaneous increment (result 0).

Optional Feature:
- Macro HRM_IO_CTRL_CNT_EN.
- Defined: counters implemented as above.
- Undefined: no counter flops; in_count/out_count tied to 0; cnt_clr ignored. Ports remain present.

Test Plan:
- Reset release, no stimulus -> cpu_debug=1, in_ready=1, out_valid=0, all strobes 0, counters 0.
- Host pushes 0x23, 0x15, 0x11, 0x22 back-to-back with INBOX not full -> four single-cycle cpu_in_wr pulses carrying 0x23, 0x15, 0x11, 0x22 in order, never adjacent; in_count=4.
- cpu_in_full=1 while host offers 0x5A -> byte held, in_ready=0, no cpu_in_wr; release full -> one cpu_in_wr with 0x5A exactly one cycle later.
- OUTBOX model holding 0x46, 0x2A with out_ready=0 -> single cpu_out_rd, out_valid=1, out_data=0x46 stable. Then out_ready=1 -> 0x46 consumed, then 0x2A delivered; out_count=2; OUTBOX ends empty with no extra pop.
- run_mode=0, step_req held high 10 cycles, then toggled twice -> exactly 3 one-cycle cpu_nxtInstr pulses. run_mode=1 -> cpu_debug=0 next cycle; step edges produce no pulses.
- With HRM_IO_CTRL_CNT_EN: force in_count to all-ones, one write -> 0. cnt_clr coincident with cpu_out_rd -> out_count=0. Without the macro, counters read 0 throughout.

Source files
------------

// File: rtl/hrm_io_ctrl_if.sv
// hrm_io_ctrl_if
//
// Host-side byte streams of the hrmcpu I/O controller.
//
// Signals:
//   in_valid / in_data / in_ready    host -> controller byte stream (feeds CPU INBOX)
//   out_valid / out_data / out_ready controller -> host byte stream (drains CPU OUTBOX)
//
// Modports:
//   master  the host logic (UART / loader) side
//   slave   the controller side (hrm_io_ctrl)

interface hrm_io_ctrl_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/hrm_io_ctrl.sv
// hrm_io_ctrl
//
// Host-side controller between the board host logic (UART / loader) and the
// hrmcpu core. Bytes from the host stream are written one at a time into the
// CPU INBOX, bytes in the CPU OUTBOX are popped and offered to the host, and
// the CPU is sequenced either free-running or single-stepped.
//
// Optional feature: define HRM_IO_CTRL_CNT_EN to build the transferred-byte
// counters. Without it in_count/out_count read 0 and cnt_clr is ignored.
//
// Parameters:
//   CNT_W          width of the in/out byte counters
//
// Ports:
//   clk            system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   host           host byte streams (hrm_io_ctrl_if.slave)
//   run_mode       1 = free run, 0 = debug / single step
//   step_req       level; each rising edge requests one instruction step
//   cnt_clr        synchronous clear of both counters
//   in_count       bytes written to the INBOX
//   out_count      bytes popped from the OUTBOX
//   cpu_in_data    INBOX write data
//   cpu_in_wr      INBOX write strobe
//   cpu_in_full    INBOX full
//   cpu_out_data   OUTBOX head data (first-word fall-through)
//   cpu_out_rd     OUTBOX pop strobe
//   cpu_out_empty  OUTBOX empty
//   cpu_debug      CPU halt / step mode
//   cpu_nxtInstr   single-step pulse

module hrm_io_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             i_rst_n,
    hrm_io_ctrl_if.slave     host,
    input  logic             run_mode,
    input  logic             step_req,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] in_count,
    output logic [CNT_W-1:0] out_count,
    output logic [7:0]       cpu_in_data,
    output logic             cpu_in_wr,
    input  logic             cpu_in_full,
    input  logic [7:0]       cpu_out_data,
    output logic             cpu_out_rd,
    input  logic             cpu_out_empty,
    output logic             cpu_debug,
    output logic             cpu_nxtInstr
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GUARD = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [7:0] ib;
    logic       ib_full;
    logic [1:0] ob_state;
    logic       out_valid_q;
    logic [7:0] out_data_q;
    logic       step_q;

    assign host.in_ready  = !ib_full;
    assign host.out_valid = out_valid_q;
    assign host.out_data  = out_data_q;

    // Inbox path: a one-entry holding register. The !cpu_in_wr term keeps
    // strobes at least one idle cycle apart, so a full flag that has not yet
    // caught up with the previous write is never trusted.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ib          <= 8'h00;
            ib_full     <= 1'b0;
            cpu_in_wr   <= 1'b0;
            cpu_in_data <= 8'h00;
        end else begin
            cpu_in_wr <= 1'b0;
            if (ib_full && !cpu_in_full && !cpu_in_wr) begin
                cpu_in_wr   <= 1'b1;
                cpu_in_data <= ib;
                ib_full     <= 1'b0;
            end else if (host.in_valid && !ib_full) begin
                ib      <= host.in_data;
                ib_full <= 1'b1;
            end
        end
    end

    // Outbox path: the GUARD state waits one cycle after each pop so that
    // cpu_out_empty reflects the pop before the next IDLE decision.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ob_state    <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            cpu_out_rd  <= 1'b0;
        end else begin
            case (ob_state)
                ST_IDLE: begin
                    if (!cpu_out_empty) begin
                        out_data_q <= cpu_out_data;
                        cpu_out_rd <= 1'b1;
                        ob_state   <= ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    cpu_out_rd  <= 1'b0;
                    out_valid_q <= 1'b1;
                    ob_state    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (host.out_ready) begin
                        out_valid_q <= 1'b0;
                        ob_state    <= ST_IDLE;
                    end
                end
                default: begin
                    cpu_out_rd  <= 1'b0;
                    out_valid_q <= 1'b0;
                    ob_state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Run control: step edges are only honoured while run_mode is low in the
    // same cycle; edges seen during free run are dropped, not remembered.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cpu_debug    <= 1'b1;
            step_q       <= 1'b0;
            cpu_nxtInstr <= 1'b0;
        end else begin
            cpu_debug    <= !run_mode;
            step_q       <= step_req;
            cpu_nxtInstr <= step_req && !step_q && !run_mode;
        end
    end

`ifdef HRM_IO_CTRL_CNT_EN
    // Byte counters; a clear wins over an increment in the same cycle.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            in_count  <= '0;
            out_count <= '0;
        end else if (cnt_clr) begin
            in_count  <= '0;
            out_count <= '0;
        end else begin
            if (cpu_in_wr) begin
                in_count <= in_count + CNT_W'(1);
            end
            if (cpu_out_rd) begin
                out_count <= out_count + CNT_W'(1);
            end
        end
    end
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign in_count       = '0;
    assign out_count      = '0;
`endif

endmodule

// File: tb/tb_hrm_io_ctrl.sv
// tb_hrm_io_ctrl
//
// Directed testbench for hrm_io_ctrl. A small OUTBOX model (first-word
// fall-through FIFO) sits on the CPU side; the INBOX full flag is driven
// directly. The counters are built narrow (CNT_W = 4) so wrap-around is
// reachable with a handful of writes. Expected counter values depend on
// whether HRM_IO_CTRL_CNT_EN is defined.

module tb_hrm_io_ctrl;

    localparam int CNT_W = 4;

`ifdef HRM_IO_CTRL_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             i_rst_n;
    logic             run_mode;
    logic             step_req;
    logic             cnt_clr;
    logic [CNT_W-1:0] in_count;
    logic [CNT_W-1:0] out_count;
    logic [7:0]       cpu_in_data;
    logic             cpu_in_wr;
    logic             cpu_in_full;
    logic [7:0]       cpu_out_data;
    logic             cpu_out_rd;
    logic             cpu_out_empty;
    logic             cpu_debug;
    logic             cpu_nxtInstr;

    hrm_io_ctrl_if bus ();

    hrm_io_ctrl #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .i_rst_n       (i_rst_n),
        .host          (bus),
        .run_mode      (run_mode),
        .step_req      (step_req),
        .cnt_clr       (cnt_clr),
        .in_count      (in_count),
        .out_count     (out_count),
        .cpu_in_data   (cpu_in_data),
        .cpu_in_wr     (cpu_in_wr),
        .cpu_in_full   (cpu_in_full),
        .cpu_out_data  (cpu_out_data),
        .cpu_out_rd    (cpu_out_rd),
        .cpu_out_empty (cpu_out_empty),
        .cpu_debug     (cpu_debug),
        .cpu_nxtInstr  (cpu_nxtInstr)
    );

    always #5 clk = ~clk;

    // OUTBOX model: 4-entry ring, popped on each cpu_out_rd edge
    logic [7:0] ob_mem [0:3];
    int         ob_head = 0;
    int         ob_tail = 0;
    int         pops    = 0;

    assign cpu_out_empty = (ob_head == ob_tail);
    assign cpu_out_data  = ob_mem[ob_head[1:0]];

    always @(posedge clk) begin
        if (cpu_out_rd && (ob_head != ob_tail)) begin
            ob_head <= ob_head + 1;
        end
        if (cpu_out_rd) begin
            pops <= pops + 1;
        end
    end

    int   total = 0;
    int   bad   = 0;
    int   pulses;
    logic prev_pulse;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic ob_load(input logic [7:0] b);
        ob_mem[ob_tail[1:0]] = b;
        ob_tail++;
    endtask

    // Push one byte through the inbox path and check its INBOX write.
    task automatic push_byte(input logic [7:0] b);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        check_output("push_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!cpu_in_wr && n < 5) begin
            tick();
            n++;
        end
        check_output("push_wr", cpu_in_wr, 1);
        check_output("push_data", cpu_in_data, b);
        tick();
    endtask

    // Advance a cycle, counting step pulses and catching wide pulses.
    task automatic step_tick();
        tick();
        if (cpu_nxtInstr) begin
            check_output("step_width", prev_pulse, 0);
            pulses++;
        end
        prev_pulse = cpu_nxtInstr;
    endtask

    initial begin
        logic [7:0] burst [0:3];
        logic [7:0] exp_out [0:1];
        int sent;
        int got;
        logic prev_wr;
        logic hs;

        burst[0] = 8'h23; burst[1] = 8'h15; burst[2] = 8'h11; burst[3] = 8'h22;
        exp_out[0] = 8'h46; exp_out[1] = 8'h2A;

        i_rst_n       = 1'b0;
        run_mode      = 1'b0;
        step_req      = 1'b0;
        cnt_clr       = 1'b0;
        cpu_in_full   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        i_rst_n = 1'b1;
        tick();

        // reset state
        check_output("rst_debug", cpu_debug, 1);
        check_output("rst_in_ready", bus.in_ready, 1);
        check_output("rst_out_valid", bus.out_valid, 0);
        check_output("rst_out_data", bus.out_data, 0);
        check_output("rst_in_wr", cpu_in_wr, 0);
        check_output("rst_in_data", cpu_in_data, 0);
        check_output("rst_out_rd", cpu_out_rd, 0);
        check_output("rst_nxt", cpu_nxtInstr, 0);
        check_output("rst_in_count", in_count, 0);
        check_output("rst_out_count", out_count, 0);

        // back-to-back host bytes into a non-full INBOX
        sent = 0;
        got = 0;
        prev_wr = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = burst[0];
        for (int c = 0; c < 30 && got < 4; c++) begin
            hs = bus.in_valid && bus.in_ready;
            tick();
            if (hs) begin
                sent++;
                if (sent < 4) bus.in_data = burst[sent];
                else bus.in_valid = 1'b0;
            end
            if (cpu_in_wr) begin
                check_output("burst_data", cpu_in_data, burst[got]);
                check_output("burst_gap", prev_wr, 0);
                got++;
            end
            prev_wr = cpu_in_wr;
        end
        bus.in_valid = 1'b0;
        check_output("burst_writes", got, 4);
        tick();
        check_output("burst_in_count", in_count, CNT_ON ? 4 : 0);

        // INBOX full holds the byte
        cpu_in_full  = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        tick();
        bus.in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check_output("full_in_ready", bus.in_ready, 0);
            check_output("full_no_wr", cpu_in_wr, 0);
            tick();
        end
        cpu_in_full = 1'b0;
        tick();
        check_output("full_release_wr", cpu_in_wr, 1);
        check_output("full_release_data", cpu_in_data, 8'h5A);
        tick();
        check_output("full_single_wr", cpu_in_wr, 0);
        check_output("full_in_ready_back", bus.in_ready, 1);
        check_output("full_in_count", in_count, CNT_ON ? 5 : 0);

        // OUTBOX drain with host stalled, then consuming
        ob_load(8'h46);
        ob_load(8'h2A);
        tick();
        check_output("ob_rd_pulse", cpu_out_rd, 1);
        check_output("ob_valid_early", bus.out_valid, 0);
        tick();
        check_output("ob_rd_drop", cpu_out_rd, 0);
        check_output("ob_valid", bus.out_valid, 1);
        check_output("ob_data", bus.out_data, 8'h46);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_output("ob_stall_valid", bus.out_valid, 1);
            check_output("ob_stall_data", bus.out_data, 8'h46);
            check_output("ob_stall_rd", cpu_out_rd, 0);
        end
        check_output("ob_stall_pops", pops, 1);
        bus.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.out_valid) begin
                check_output("ob_stream_data", bus.out_data, (got < 2) ? exp_out[got] : 8'hFF);
                got++;
            end
            tick();
        end
        bus.out_ready = 1'b0;
        check_output("ob_delivered", got, 2);
        check_output("ob_pops", pops, 2);
        check_output("ob_empty", cpu_out_empty, 1);
        check_output("ob_valid_end", bus.out_valid, 0);
        check_output("ob_out_count", out_count, CNT_ON ? 2 : 0);

        // single step: long hold then two toggles
        pulses = 0;
        prev_pulse = 1'b0;
        step_req = 1'b1;
        repeat (10) step_tick();
        step_req = 1'b0;
        repeat (2) step_tick();
        step_req = 1'b1;
        repeat (2) step_tick();
        step_req = 1'b0;
        repeat (2) step_tick();
        step_req = 1'b1;
        repeat (2) step_tick();
        step_req = 1'b0;
        repeat (2) step_tick();
        check_output("step_pulses", pulses, 3);

        // free run: debug drops a cycle later, steps ignored
        run_mode = 1'b1;
        check_output("run_debug_before", cpu_debug, 1);
        tick();
        check_output("run_debug_after", cpu_debug, 0);
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            step_req = 1'b1;
            step_tick();
            step_req = 1'b0;
            step_tick();
        end
        check_output("run_no_pulses", pulses, 0);

        // mode switch coincident with a step edge
        run_mode = 1'b0;
        step_req = 1'b1;
        tick();
        check_output("switch_to_debug_pulse", cpu_nxtInstr, 1);
        check_output("switch_debug", cpu_debug, 1);
        step_req = 1'b0;
        tick();
        check_output("switch_pulse_end", cpu_nxtInstr, 0);
        run_mode = 1'b1;
        step_req = 1'b1;
        tick();
        check_output("switch_to_run_pulse", cpu_nxtInstr, 0);
        tick();
        check_output("switch_to_run_later", cpu_nxtInstr, 0);
        step_req = 1'b0;
        run_mode = 1'b0;
        tick();

        // counter wrap: 10 more writes reach all-ones, one more wraps
        for (int i = 0; i < 10; i++) begin
            push_byte(8'(8'h30 + i));
        end
        check_output("wrap_all_ones", in_count, CNT_ON ? 15 : 0);
        push_byte(8'hA5);
        check_output("wrap_zero", in_count, 0);

        // clear coincident with an OUTBOX pop
        ob_load(8'h99);
        tick();
        check_output("clr_rd_pulse", cpu_out_rd, 1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check_output("clr_out_count", out_count, 0);
        check_output("clr_in_count", in_count, 0);
        bus.out_ready = 1'b1;
        repeat (4) tick();
        bus.out_ready = 1'b0;
        check_output("clr_out_count_hold", out_count, 0);
        check_output("clr_pops", pops, 3);

        // reset while a byte is held
        cpu_in_full  = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        tick();
        check_output("mid_held", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        check_output("mid_rst_ready", bus.in_ready, 1);
        check_output("mid_rst_wr", cpu_in_wr, 0);
        cpu_in_full = 1'b0;
        tick();
        i_rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_output("mid_no_wr", cpu_in_wr, 0);
        end
        check_output("mid_in_count", in_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
